// File: rtl/difftest_arch_delayed_update_queue_if.sv
// Bus between the writeback capture side and the difftest batch packer.
// Carries the per-channel update inputs and the single-entry drain stream.
// The queue takes the slave view; the producer/consumer takes the master view.
interface difftest_arch_delayed_update_queue_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*ADDR_W-1:0] in_address;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_nack;
    logic [NUM_CH-1:0]        in_is_fp;

    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_address;
    logic [DATA_W-1:0]        out_data;
    logic                     out_nack;
    logic                     out_is_fp;
    logic [7:0]               out_coreid;
    logic [7:0]               out_index;

    modport master (
        output in_valid, in_address, in_data, in_nack, in_is_fp, out_ready,
        input  out_valid, out_address, out_data, out_nack, out_is_fp,
               out_coreid, out_index
    );

    modport slave (
        input  in_valid, in_address, in_data, in_nack, in_is_fp, out_ready,
        output out_valid, out_address, out_data, out_nack, out_is_fp,
               out_coreid, out_index
    );
endinterface

// File: rtl/difftest_arch_delayed_update_queue.sv
// Multi-channel delayed architectural writeback queue.
// Up to NUM_CH updates are captured per cycle in ascending channel order into
// an in-order FIFO, each stamped with a wrapping 8-bit sequence index, and
// drained one per cycle. Updates that do not fit are dropped and counted.
// Optional build macro DIFFTEST_DELAYED_NACK_FILTER_EN: nacked updates are
// discarded before slot allocation and out_nack is tied low.
module difftest_arch_delayed_update_queue #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [7:0]                io_coreid,
    difftest_arch_delayed_update_queue_if.slave bus,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow,
    output logic [15:0]               drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = 3;

    // Entry storage; contents are don't-care until written.
    logic [ADDR_W-1:0] mem_address [DEPTH];
    logic [DATA_W-1:0] mem_data    [DEPTH];
    logic              mem_is_fp   [DEPTH];
    logic [7:0]        mem_coreid  [DEPTH];
    logic [7:0]        mem_index   [DEPTH];
`ifndef DIFFTEST_DELAYED_NACK_FILTER_EN
    logic              mem_nack    [DEPTH];
`endif

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [7:0]        seq;

    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] wr_en;
    logic [PTR_W-1:0]  wr_slot [NUM_CH];
    logic [7:0]        wr_seq  [NUM_CH];
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  n_acc;
    logic [CH_W-1:0]   n_drop;
    logic              deq;
    logic [16:0]       drop_sum;

    // Candidate channels: enable gates capture; nacks optionally filtered out
    // so they never consume space, sequence numbers or drop credit.
`ifdef DIFFTEST_DELAYED_NACK_FILTER_EN
    assign cand = bus.in_valid & ~bus.in_nack & {NUM_CH{enable}};
`else
    assign cand = bus.in_valid & {NUM_CH{enable}};
`endif

    assign deq      = (occupancy != '0) && bus.out_ready;
    assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

    // Slot allocation: free space is taken before this cycle's dequeue, so a
    // same-cycle pop never makes room for a push.
    always_comb begin
        free   = CNT_W'(DEPTH) - occupancy;
        n_acc  = '0;
        n_drop = '0;
        wr_en  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_slot[i] = wr_ptr + n_acc[PTR_W-1:0];
            wr_seq[i]  = seq + 8'(n_acc);
            if (cand[i]) begin
                if (n_acc < free) begin
                    wr_en[i] = 1'b1;
                    n_acc    = n_acc + 1'b1;
                end else begin
                    n_drop = n_drop + 1'b1;
                end
            end
        end
    end

    // Control state: pointers, occupancy, sequence counter and drop tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr + n_acc[PTR_W-1:0];
            rd_ptr    <= rd_ptr + PTR_W'(deq);
            occupancy <= occupancy + n_acc - CNT_W'(deq);
            seq       <= seq + 8'(n_acc);
            if (n_drop != '0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    // Entry writes: accepted channels land in consecutive slots.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
                mem_address[wr_slot[i]] <= bus.in_address[i*ADDR_W +: ADDR_W];
                mem_data[wr_slot[i]]    <= bus.in_data[i*DATA_W +: DATA_W];
                mem_is_fp[wr_slot[i]]   <= bus.in_is_fp[i];
                mem_coreid[wr_slot[i]]  <= io_coreid;
                mem_index[wr_slot[i]]   <= wr_seq[i];
`ifndef DIFFTEST_DELAYED_NACK_FILTER_EN
                mem_nack[wr_slot[i]]    <= bus.in_nack[i];
`endif
            end
        end
    end

    // Head presentation; data fields are forced to zero while the queue is empty.
    always_comb begin
        bus.out_valid   = (occupancy != '0);
        bus.out_address = '0;
        bus.out_data    = '0;
        bus.out_nack    = 1'b0;
        bus.out_is_fp   = 1'b0;
        bus.out_coreid  = '0;
        bus.out_index   = '0;
        if (occupancy != '0) begin
            bus.out_address = mem_address[rd_ptr];
            bus.out_data    = mem_data[rd_ptr];
            bus.out_is_fp   = mem_is_fp[rd_ptr];
            bus.out_coreid  = mem_coreid[rd_ptr];
            bus.out_index   = mem_index[rd_ptr];
`ifndef DIFFTEST_DELAYED_NACK_FILTER_EN
            bus.out_nack    = mem_nack[rd_ptr];
`endif
        end
    end
endmodule
